// File: rtl/udma_stream_framer.sv
// Stream framer: slices a raw sample stream into fixed-length frames with
// sot/eot markers, a stream id and a datasize tag, behind a small register file.
module udma_stream_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           cfg_data_i,
  input  logic [4:0]            cfg_addr_i,
  input  logic                  cfg_valid_i,
  input  logic                  cfg_rwn_i,
  output logic                  cfg_ready_o,
  output logic [31:0]           cfg_data_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] str_data_o,
  output logic [ID_WIDTH-1:0]   str_id_o,
  output logic [1:0]            str_datasize_o,
  output logic                  str_valid_o,
  output logic                  str_sot_o,
  output logic                  str_eot_o,
  input  logic                  str_ready_i,
  output logic                  frame_event_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  en_q, en_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [1:0]            ds_q, ds_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  flen_q, flen_d;
  logic [ID_WIDTH-1:0]   fid_q, fid_d;
  logic [1:0]            fds_q, fds_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic [ID_WIDTH-1:0]   oid_q, oid_d;
  logic [1:0]            ods_q, ods_d;
  logic                  ovld_q, ovld_d;
  logic                  osot_q, osot_d;
  logic                  oeot_q, oeot_d;
  logic                  ev_q, ev_d;
  logic [15:0]           fcnt_q, fcnt_d;

  logic                  wr_en, clr, acc, first, last, busy;
  logic [LEN_WIDTH-1:0]  eff_len, cur_len;
  logic                  unused_cfg;

  assign unused_cfg = ^cfg_data_i;
  assign wr_en = cfg_valid_i & ~cfg_rwn_i;
  assign clr   = wr_en & (cfg_addr_i == 5'd0) & cfg_data_i[1];

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      len_q   <= LEN_WIDTH'(1);
      id_q    <= '0;
      ds_q    <= 2'd2;
      cnt_q   <= '0;
      flen_q  <= LEN_WIDTH'(1);
      fid_q   <= '0;
      fds_q   <= 2'd2;
      odata_q <= '0;
      oid_q   <= '0;
      ods_q   <= 2'd2;
      ovld_q  <= 1'b0;
      osot_q  <= 1'b0;
      oeot_q  <= 1'b0;
      ev_q    <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      len_q   <= len_d;
      id_q    <= id_d;
      ds_q    <= ds_d;
      cnt_q   <= cnt_d;
      flen_q  <= flen_d;
      fid_q   <= fid_d;
      fds_q   <= fds_d;
      odata_q <= odata_d;
      oid_q   <= oid_d;
      ods_q   <= ods_d;
      ovld_q  <= ovld_d;
      osot_q  <= osot_d;
      oeot_q  <= oeot_d;
      ev_q    <= ev_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Register file and frame datapath; frame parameters are captured on sot
  always_comb begin
    en_d  = en_q;
    len_d = len_q;
    id_d  = id_q;
    ds_d  = ds_q;
    if (wr_en) begin
      case (cfg_addr_i)
        5'd0: en_d = cfg_data_i[0] & ~cfg_data_i[1];
        5'd1: len_d = cfg_data_i[LEN_WIDTH-1:0];
        5'd2: begin
          id_d = cfg_data_i[ID_WIDTH-1:0];
          ds_d = cfg_data_i[9:8];
        end
        default: ;
      endcase
    end

    acc     = in_valid_i & in_ready_o;
    first   = (cnt_q == '0);
    eff_len = (len_q == '0) ? LEN_WIDTH'(1) : len_q;
    cur_len = first ? eff_len : flen_q;
    last    = (cnt_q == cur_len - LEN_WIDTH'(1));

    cnt_d  = cnt_q;
    flen_d = flen_q;
    fid_d  = fid_q;
    fds_d  = fds_q;
    if (acc) begin
      cnt_d = last ? '0 : cnt_q + LEN_WIDTH'(1);
      if (first) begin
        flen_d = eff_len;
        fid_d  = id_q;
        fds_d  = ds_q;
      end
    end
    if (clr) cnt_d = '0;

    odata_d = odata_q;
    oid_d   = oid_q;
    ods_d   = ods_q;
    osot_d  = osot_q;
    oeot_d  = oeot_q;
    ovld_d  = ovld_q;
    if (clr) begin
      ovld_d = 1'b0;
    end else if (acc) begin
      ovld_d  = 1'b1;
      odata_d = in_data_i;
      osot_d  = first;
      oeot_d  = last;
      oid_d   = first ? id_q : fid_q;
      ods_d   = first ? ds_q : fds_q;
    end else if (str_ready_i) begin
      ovld_d = 1'b0;
    end

    ev_d   = ovld_q & str_ready_i & oeot_q & ~clr;
    fcnt_d = clr ? 16'd0 : fcnt_q + 16'(ev_d);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (en_q) state_d = S_RUN;
      S_RUN:   if (!en_d) state_d = (cnt_d == '0) ? S_IDLE : S_DRAIN;
      S_DRAIN: if (acc && last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  always_comb begin
    in_ready_o  = (state_q != S_IDLE) & (~ovld_q | str_ready_i);
    busy        = (state_q != S_IDLE) | ovld_q;
    cfg_ready_o = 1'b1;
    cfg_data_o  = '0;
    if (cfg_valid_i && cfg_rwn_i) begin
      case (cfg_addr_i)
        5'd0: cfg_data_o[0] = en_q;
        5'd1: cfg_data_o[LEN_WIDTH-1:0] = len_q;
        5'd2: begin
          cfg_data_o[ID_WIDTH-1:0] = id_q;
          cfg_data_o[9:8] = ds_q;
        end
        5'd3: begin
          cfg_data_o[15:0]  = fcnt_q;
          cfg_data_o[16]    = busy;
          cfg_data_o[18:17] = state_q;
        end
        default: ;
      endcase
    end
  end

  assign str_data_o     = odata_q;
  assign str_id_o       = oid_q;
  assign str_datasize_o = ods_q;
  assign str_valid_o    = ovld_q;
  assign str_sot_o      = osot_q;
  assign str_eot_o      = oeot_q;
  assign frame_event_o  = ev_q;

endmodule

// File: tb/tb_udma_stream_framer.sv
// Scoreboard bench for udma_stream_framer: directed frames, stalls,
// drain, clear and reset; expected beats are queued at input acceptance.
module tb_udma_stream_framer;

  typedef struct packed {
    logic [31:0] d;
    logic        sot;
    logic        eot;
    logic [7:0]  id;
    logic [1:0]  ds;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_data = '0;
  logic [4:0]  cfg_addr = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_rwn = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_rdata;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] str_data;
  logic [7:0]  str_id;
  logic [1:0]  str_ds;
  logic        str_valid, str_sot, str_eot;
  logic        str_ready = 1'b1;
  logic        frame_event;

  int    errs = 0;
  int    checks = 0;
  int    ev_cnt = 0;
  int    rdy_mode = 0;
  beat_t q[$];
  beat_t mon_cur, mon_snap, mon_exp;
  bit    hold = 0;

  udma_stream_framer dut (
    .sys_clk_i(clk),
    .rst_i(rst),
    .cfg_data_i(cfg_data),
    .cfg_addr_i(cfg_addr),
    .cfg_valid_i(cfg_valid),
    .cfg_rwn_i(cfg_rwn),
    .cfg_ready_o(cfg_ready),
    .cfg_data_o(cfg_rdata),
    .in_data_i(in_data),
    .in_valid_i(in_valid),
    .in_ready_o(in_ready),
    .str_data_o(str_data),
    .str_id_o(str_id),
    .str_datasize_o(str_ds),
    .str_valid_o(str_valid),
    .str_sot_o(str_sot),
    .str_eot_o(str_eot),
    .str_ready_i(str_ready),
    .frame_event_o(frame_event)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #2;
    case (rdy_mode)
      0: str_ready = 1'b1;
      1: str_ready = ~str_ready;
      default: str_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold = 0;
    end else begin
      if (frame_event) ev_cnt++;
      if (str_valid) begin
        mon_cur = '{str_data, str_sot, str_eot, str_id, str_ds};
        if (hold) chk("hold_stable", 64'(mon_cur), 64'(mon_snap));
        if (str_ready) begin
          hold = 0;
          if (q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL extra_beat: got %0h expected none", mon_cur);
          end else begin
            mon_exp = q.pop_front();
            chk("beat", 64'(mon_cur), 64'(mon_exp));
          end
        end else begin
          hold = 1;
          mon_snap = mon_cur;
          chk("in_ready_stall", 64'(in_ready), 64'(0));
        end
      end else begin
        hold = 0;
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_rwn = 1'b0;
    cfg_addr = a;
    cfg_data = d;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_rwn = 1'b1;
    cfg_addr = a;
    @(negedge clk);
    d = cfg_rdata;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e,
                      input logic [7:0] id, input logic [1:0] ds);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 for %0h", d);
    end else begin
      q.push_back('{d, s, e, id, ds});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_run(input int base, input int first, input int n,
                          input int len, input logic [7:0] id,
                          input logic [1:0] ds);
    for (int i = first; i < first + n; i++)
      send(32'(base + i), (i % len) == 0, (i % len) == len - 1, id, ds);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while ((q.size() != 0 || str_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(q.size()), 64'(0));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] r;
  int e0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(str_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs", 64'({str_data, str_id, str_ds, str_sot, str_eot,
                         frame_event}), 64'({32'h0, 8'h0, 2'd2, 3'b000}));
    @(posedge clk);
    #1;
    rd(5'd3, r); chk("rst_status", 64'(r), 64'(0));
    rd(5'd1, r); chk("rst_len", 64'(r), 64'(1));
    rd(5'd2, r); chk("rst_cfg", 64'(r), 64'(32'h200));
    rd(5'd7, r); chk("unmapped", 64'(r), 64'(0));

    // Two 4-beat frames back-to-back
    e0 = ev_cnt;
    wr(5'd1, 32'd4);
    wr(5'd2, 32'h25A);
    wr(5'd0, 32'd1);
    send_run(0, 0, 8, 4, 8'h5A, 2'd2);
    drain("t1_drain");
    chk("t1_events", 64'(ev_cnt - e0), 64'(2));
    rd(5'd3, r); chk("t1_status", 64'(r), 64'(32'h30002));
    wr(5'd3, 32'hFFFF);
    rd(5'd3, r); chk("t1_status_ro", 64'(r), 64'(32'h30002));
    wr(5'd0, 32'd0);

    // Downstream ready toggling every cycle
    e0 = ev_cnt;
    rdy_mode = 1;
    wr(5'd1, 32'd3);
    wr(5'd2, 32'h133);
    wr(5'd0, 32'd1);
    send_run(100, 0, 6, 3, 8'h33, 2'd1);
    drain("t2_drain");
    chk("t2_events", 64'(ev_cnt - e0), 64'(2));
    wr(5'd0, 32'd0);
    rdy_mode = 0;

    // Disable mid-frame: drain the rest of the frame, then idle
    e0 = ev_cnt;
    wr(5'd1, 32'd4);
    wr(5'd2, 32'h211);
    wr(5'd0, 32'd1);
    send_run(200, 0, 2, 4, 8'h11, 2'd2);
    wr(5'd0, 32'd0);
    rd(5'd3, r); chk("t3_drain_state", 64'(r), 64'(32'h50004));
    send_run(200, 2, 2, 4, 8'h11, 2'd2);
    drain("t3_drain");
    chk("t3_events", 64'(ev_cnt - e0), 64'(1));
    chk("t3_in_ready", 64'(in_ready), 64'(0));
    rd(5'd3, r); chk("t3_status", 64'(r), 64'(32'h5));

    // Clear with a beat stalled in the output register
    wr(5'd0, 32'd1);
    send_run(300, 0, 2, 4, 8'h11, 2'd2);
    rdy_mode = 2;
    e0 = ev_cnt;
    wr(5'd0, 32'd2);
    q.delete();
    chk("t4_valid_clr", 64'(str_valid), 64'(0));
    rd(5'd3, r); chk("t4_status", 64'(r), 64'(0));
    rd(5'd0, r); chk("t4_ctrl", 64'(r), 64'(0));
    chk("t4_no_event", 64'(ev_cnt - e0), 64'(0));
    rdy_mode = 0;
    wr(5'd0, 32'd1);
    send_run(400, 0, 4, 4, 8'h11, 2'd2);
    drain("t4_drain");
    chk("t4_events", 64'(ev_cnt - e0), 64'(1));
    rd(5'd3, r); chk("t4_status2", 64'(r), 64'(32'h30001));
    wr(5'd0, 32'd0);

    // Single-beat frames: LEN=1 and LEN=0
    e0 = ev_cnt;
    wr(5'd1, 32'd1);
    wr(5'd0, 32'd1);
    send_run(500, 0, 3, 1, 8'h11, 2'd2);
    drain("t5_drain1");
    wr(5'd0, 32'd0);
    wr(5'd1, 32'd0);
    rd(5'd1, r); chk("t5_len0", 64'(r), 64'(0));
    wr(5'd0, 32'd1);
    send_run(600, 0, 3, 1, 8'h11, 2'd2);
    drain("t5_drain0");
    chk("t5_events", 64'(ev_cnt - e0), 64'(6));
    wr(5'd0, 32'd0);

    // Reset mid-frame
    wr(5'd1, 32'd5);
    wr(5'd0, 32'd1);
    send_run(700, 0, 2, 5, 8'h11, 2'd2);
    rst = 1'b1;
    #1;
    q.delete();
    chk("t6_outs", 64'({str_valid, str_sot, str_eot, frame_event, in_ready,
                        str_data, str_id, str_ds}),
        64'({5'b00000, 32'h0, 8'h0, 2'd2}));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(5'd3, r); chk("t6_status", 64'(r), 64'(0));
    rd(5'd1, r); chk("t6_len", 64'(r), 64'(1));
    rd(5'd2, r); chk("t6_cfg", 64'(r), 64'(32'h200));
    rd(5'd0, r); chk("t6_ctrl", 64'(r), 64'(0));
    repeat (3) @(negedge clk);
    chk("t6_no_beat", 64'(str_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/udma_stream_framer.md
UDMA_STREAM_FRAMER -- requirements
Module: udma_stream_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the sample and stream data path.
REQ-002 Parameter ID_WIDTH, default 8, width of the stream_id tag.
REQ-003 Parameter LEN_WIDTH, default 16, width of the frame-length register and beat counter.
REQ-004 sys_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 cfg_data_i  in  32  register write data.
REQ-007 cfg_addr_i  in  5  register word index.
REQ-008 cfg_valid_i  in  1  register access strobe.
REQ-009 cfg_rwn_i  in  1  1 = read, 0 = write.
REQ-010 cfg_ready_o  out  1  access accepted; tied 1.
REQ-011 cfg_data_o  out  32  combinational read data.
REQ-012 in_data_i  in  DATA_WIDTH  raw sample.
REQ-013 in_valid_i  in  1  sample valid.
REQ-014 in_ready_o  out  1  sample accepted when in_valid_i & in_ready_o.
REQ-015 str_data_o  out  DATA_WIDTH  framed stream data to the filter stream input.
REQ-016 str_id_o  out  ID_WIDTH  stream_id of the current frame.
REQ-017 str_datasize_o  out  2  datasize of the current frame.
REQ-018 str_valid_o / str_sot_o / str_eot_o  out  1 each  beat valid, first beat, last beat.
REQ-019 str_ready_i  in  1  downstream ready.
REQ-020 frame_event_o  out  1  one-cycle pulse per completed frame.

Function
REQ-021 Registers: idx 0 CTRL (bit0 EN, bit1 CLR write-only self-clearing); idx 1 LEN [LEN_WIDTH-1:0] beats per frame, 0 treated as 1; idx 2 CFG (ID [ID_WIDTH-1:0], datasize [9:8]); idx 3 STATUS read-only (frame count [15:0], busy [16], state [18:17]); writes to idx 3 and reads of unmapped indices return/do 0.
REQ-022 FSM states IDLE=0, RUN=1, DRAIN=2; IDLE->RUN when EN=1; RUN->DRAIN when EN written 0 with beat counter != 0; RUN->IDLE when EN=0 and counter == 0; DRAIN->IDLE when the eot beat is accepted at the input.
REQ-023 in_ready_o = (state != IDLE) & (!str_valid_o | str_ready_i); one output register stage, input-to-output latency exactly 1 cycle, full throughput of 1 beat/cycle.
REQ-024 Output register holds data, sot, eot, id, datasize stable while str_valid_o & !str_ready_i.
REQ-025 Beat counter increments per accepted input beat; sot = (counter == 0); eot = (counter == LEN_latched-1); counter returns to 0 after eot.
REQ-026 LEN, ID, datasize are latched at each sot beat; writes mid-frame take effect at the next frame.
REQ-027 LEN = 1: every beat carries sot=1 and eot=1.
REQ-028 frame_event_o pulses 1 cycle in the cycle after an eot beat completes the output handshake; frame count increments at the same time, wrapping 0xFFFF->0x0000.
REQ-029 CLR: next cycle state=IDLE, EN=0, counter=0, str_valid_o=0, in-flight beat discarded, frame count=0; no frame_event_o.
REQ-030 Simultaneous EN=0 write and eot input accept: state goes to IDLE, not DRAIN.
REQ-031 busy = (state != IDLE) | str_valid_o.

Reset
REQ-032 On rst_i: state IDLE, EN=0, LEN=1, ID=0, datasize=2, counter=0, frame count=0; str_valid_o, str_sot_o, str_eot_o, frame_event_o, in_ready_o all 0; str_data_o, str_id_o = 0; str_datasize_o = 2.
REQ-033 rst_i asserted mid-frame aborts the frame immediately; no partial beat is presented after release.

Verification
REQ-034 LEN=4, ID=0x5A, EN=1, 8 back-to-back samples 0..7, str_ready_i=1 -> 8 beats, sot on 0 and 4, eot on 3 and 7, id 0x5A, 2 frame_event_o pulses, STATUS count=2.
REQ-035 LEN=3, str_ready_i toggling 1/0 each cycle -> no data loss or duplication, output held stable while stalled, in_ready_o low whenever output stalled.
REQ-036 LEN=4, EN cleared after beat 1 -> state DRAIN, beats 2-3 still accepted, eot on beat 3, then IDLE, in_ready_o=0.
REQ-037 LEN=4, CLR written after 2 beats with output stalled -> str_valid_o=0 next cycle, count unchanged at 0, next frame after EN starts with sot.
REQ-038 LEN=1 and LEN=0 -> every beat sot=eot=1, one frame_event_o per beat.
REQ-039 rst_i pulsed mid-frame with LEN=5 -> all outputs at reset values, registers at defaults, STATUS reads 0.
